icache_sa: RTL and testbench
============================

Name: icache_sa

Overview:
- Parametrised set-associative instruction cache; successor to the single-word direct-mapped icache.
- Sits between the fetch stage (icache_if side) and the memory arbiter (caches_if side).
- Adds configurable sets/ways/words-per-block, a multi-word fill FSM, round-robin replacement, flush, arbiter hold and hit/miss counters.

Parameters:
- SETS, 8, number of sets; power of 2, at least 2.
- WAYS, 2, associativity; one of 1, 2 or 4.
- WORDS, 2, 32-bit words per block; power of 2, at least 1.

Ports:
- CLK  in  1  clock.
- nRST  in  1  reset.
- imemREN  in  1  fetch request.
- imemaddr  in  32  fetch byte address; bits [1:0] ignored.
- flush  in  1  invalidate all lines.
- arb_hold  in  1  dcache owns memory; no new miss may launch.
- ihit  out  1  imemload valid this cycle.
- imemload  out  32  instruction word.
- iREN  out  1  memory read request.
- iaddr  out  32  memory word address.
- iload  in  32  memory read data.
- iwait  in  1  memory not ready.
- hit_count  out  32  hits since reset.
- miss_count  out  32  misses since reset.

Interface:
- Reset nRST is asynchronous, active-low; clock CLK.

Behaviour:
- Address split:
  - byte offset [1:0]
  - word offset WOFF=log2(WORDS) bits
  - index log2(SETS) bits
  - tag = remaining upper bits
- Storage per way/set: valid bit, tag, WORDS data words. Per set: round-robin pointer, log2(WAYS) bits.
- Reset values:
  - valid all 0, pointers 0, state IDLE
  - ihit 0, imemload 0, iREN 0, iaddr 0
  - counters 0
- FSM states: IDLE, FILL, FLUSH.
- IDLE, request present (imemREN=1):
  - Lookup is combinational. A hit is any way with valid=1 and a tag match.
  - On hit: ihit=1 and imemload=the selected word in the same cycle (0-cycle latency); hit_count+1.
  - On miss with arb_hold=0: latch the block base address and the victim way; miss_count+1; go to FILL with word counter k=0.
  - On miss with arb_hold=1: stay in IDLE, ihit=0, iREN=0, no count.
- FILL:
  - Drive iREN=1 and iaddr = block base + 4k.
  - When iwait=0: store iload into word k of the victim way, then k+1.
  - After the last word: write the tag, set valid, advance the set pointer if the victim equals the pointer, return to IDLE.
  - The line is marked valid only when the final word lands. The request re-hits in the cycle after return (miss penalty = WORDS memory beats + 1).
  - imemaddr changes during FILL are ignored; the latched block completes.
  - arb_hold is ignored once FILL has started.
- Victim selection: lowest-index invalid way; if all ways are valid, the way at the set pointer.
- FLUSH:
  - flush=1 in any state moves to FLUSH at the next edge. flush takes priority over all other events.
  - FLUSH lasts one cycle: all valid bits are cleared and pointers reset to 0.
  - A FILL in progress is aborted: its line is not validated and iREN drops the following cycle.
  - Returns to IDLE.
- ihit=0 in FILL and FLUSH; imemload is 0 whenever ihit=0.
- A request with imemREN=0 has no effect and no count.
- Counters wrap modulo 2^32.
- nRST asserted mid-FILL: immediate return to reset values; partial line discarded.
- WAYS=1 degenerates to direct-mapped; pointer logic is optimised away.

Decomposition:
- Package icache_sa_pkg holds:
  - state enum icsa_state_t (IDLE, FILL, FLUSH)
  - function-style localparams for field widths (WOFF_W, IDX_W, TAG_W)
  - struct icsa_line_t {valid, tag, data[WORDS]}
  - word_t from cpu_types_pkg
- Sub-module icsa_way: one way's tag/valid/data array with a lookup port and a fill write port, instantiated WAYS times via generate.

Test Plan:
- Cold miss, default params: fetch 0x0000_0040, iwait=0 each beat -> iREN high 2 cycles at iaddr 0x40 then 0x44; the next cycle ihit=1 with the 0x40 word; miss_count=1.
- Spatial hit: after the above, fetch 0x44 -> ihit=1 in the same cycle, no iREN; hit_count=1.
- Conflict and replacement (SETS=8, WORDS=2, index bits [5:3]):
  - Fill 0x000, 0x040 and 0x080, all set 0.
  - Third fill evicts way 0 (pointer 0 -> 1).
  - Then 0x000 misses and 0x040 hits.
- iwait stalls: hold iwait=1 for 3 cycles per beat -> iaddr stays stable, no ihit until the final beat completes, data correct.
- Flush mid-fill: assert flush during the first FILL beat -> iREN low after FLUSH; a re-fetch of the same address misses again; all sets are invalid.
- arb_hold: miss with arb_hold=1 for 4 cycles -> iREN stays 0 and miss_count is unchanged until release, then the fill proceeds normally.

Source files
------------

// File: rtl/icache_sa_pkg.sv
// icache_sa shared types: FSM states, field-width helpers, line layout.
// Widths are functions so every module derives them from its own parameters.
package icache_sa_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        FLUSH
    } icsa_state_t;

    function automatic int woff_w(input int words);
        return $clog2(words);
    endfunction

    function automatic int idx_w(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int tag_w(input int sets, input int words);
        return 30 - woff_w(words) - idx_w(sets);
    endfunction

    localparam int DEF_SETS  = 8;
    localparam int DEF_WORDS = 2;
    localparam int WOFF_W    = woff_w(DEF_WORDS);
    localparam int IDX_W     = idx_w(DEF_SETS);
    localparam int TAG_W     = tag_w(DEF_SETS, DEF_WORDS);

    typedef struct packed {
        logic                         valid;
        logic [TAG_W-1:0]             tag;
        word_t [DEF_WORDS-1:0]        data;
    } icsa_line_t;

endpackage

// File: rtl/icsa_way.sv
// One cache way: valid/tag/data per set, combinational lookup,
// single-word fill write port and whole-way invalidate.
module icsa_way
    import icache_sa_pkg::*;
#(
    parameter  int SETS  = 8,
    parameter  int WORDS = 2,
    localparam int IW    = idx_w(SETS),
    localparam int TW    = tag_w(SETS, WORDS),
    localparam int WB    = (WORDS > 1) ? woff_w(WORDS) : 1
) (
    input  logic          CLK,
    input  logic          nRST,
    input  logic [IW-1:0] i_rd_idx,
    input  logic [TW-1:0] i_rd_tag,
    input  logic [WB-1:0] i_rd_woff,
    output logic          o_valid,
    output logic          o_hit,
    output word_t         o_rdata,
    input  logic          i_wr_en,
    input  logic          i_set_valid,
    input  logic          i_clr,
    input  logic [IW-1:0] i_wr_idx,
    input  logic [WB-1:0] i_wr_woff,
    input  logic [TW-1:0] i_wr_tag,
    input  word_t         i_wr_data
);

    logic [SETS-1:0] r_valid;
    logic [TW-1:0]   r_tag  [SETS];
    word_t           r_data [SETS][WORDS];

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_valid <= '0;
        end else if (i_clr) begin
            r_valid <= '0;
        end else if (i_set_valid) begin
            r_valid[i_wr_idx] <= 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (i_wr_en) begin
            r_data[i_wr_idx][i_wr_woff] <= i_wr_data;
        end
        if (i_set_valid) begin
            r_tag[i_wr_idx] <= i_wr_tag;
        end
    end

    assign o_valid = r_valid[i_rd_idx];
    assign o_hit   = o_valid && (r_tag[i_rd_idx] == i_rd_tag);
    assign o_rdata = r_data[i_rd_idx][i_rd_woff];

endmodule

// File: rtl/icache_sa.sv
// Set-associative instruction cache with multi-word block fill,
// round-robin replacement, flush, arbiter hold and hit/miss counters.
module icache_sa
    import icache_sa_pkg::*;
#(
    parameter int SETS  = 8,
    parameter int WAYS  = 2,
    parameter int WORDS = 2
) (
    input  logic  CLK,
    input  logic  nRST,
    input  logic  imemREN,
    input  word_t imemaddr,
    input  logic  flush,
    input  logic  arb_hold,
    output logic  ihit,
    output word_t imemload,
    output logic  iREN,
    output word_t iaddr,
    input  word_t iload,
    input  logic  iwait,
    output word_t hit_count,
    output word_t miss_count
);

    localparam int WOFF = woff_w(WORDS);
    localparam int IW   = idx_w(SETS);
    localparam int TW   = tag_w(SETS, WORDS);
    localparam int WB   = (WORDS > 1) ? WOFF : 1;
    localparam int PW   = (WAYS > 1) ? $clog2(WAYS) : 1;

    icsa_state_t r_state, w_next;

    logic [IW-1:0] r_idx;
    logic [TW-1:0] r_tag;
    logic [WB-1:0] r_k;
    logic [PW-1:0] r_victim;
    logic [PW-1:0] r_ptr [SETS];
    word_t         r_base;
    logic          r_refill;

    logic [IW-1:0]   w_idx;
    logic [TW-1:0]   w_tag;
    logic [WB-1:0]   w_woff;
    logic [WAYS-1:0] w_hit_vec;
    logic [WAYS-1:0] w_val_vec;
    word_t           w_rdata [WAYS];
    word_t           w_load;
    logic [PW-1:0]   w_vict;
    logic            w_found;
    logic            w_req, w_ihit, w_miss;
    logic            w_beat, w_done;
    logic            w_unused;

    assign w_idx    = imemaddr[2+WOFF +: IW];
    assign w_tag    = imemaddr[31 -: TW];
    assign w_woff   = (WORDS > 1) ? imemaddr[2 +: WB] : '0;
    assign w_unused = ^imemaddr[1:0];

    assign w_beat = (r_state == FILL) && !iwait && !flush;
    assign w_done = w_beat && (r_k == WB'(WORDS - 1));

    for (genvar g = 0; g < WAYS; g++) begin : g_way
        icsa_way #(.SETS(SETS), .WORDS(WORDS)) u_way (
            .CLK        (CLK),
            .nRST       (nRST),
            .i_rd_idx   (w_idx),
            .i_rd_tag   (w_tag),
            .i_rd_woff  (w_woff),
            .o_valid    (w_val_vec[g]),
            .o_hit      (w_hit_vec[g]),
            .o_rdata    (w_rdata[g]),
            .i_wr_en    (w_beat && (r_victim == PW'(g))),
            .i_set_valid(w_done && (r_victim == PW'(g))),
            .i_clr      (r_state == FLUSH),
            .i_wr_idx   (r_idx),
            .i_wr_woff  (r_k),
            .i_wr_tag   (r_tag),
            .i_wr_data  (iload)
        );
    end

    always_comb begin
        w_load  = '0;
        w_vict  = r_ptr[w_idx];
        w_found = 1'b0;
        for (int i = 0; i < WAYS; i++) begin
            if (w_hit_vec[i]) w_load = w_load | w_rdata[i];
            if (!w_found && !w_val_vec[i]) begin
                w_vict  = PW'(i);
                w_found = 1'b1;
            end
        end
    end

    assign w_req  = (r_state == IDLE) && imemREN && !flush;
    assign w_ihit = w_req && (|w_hit_vec);
    assign w_miss = w_req && !(|w_hit_vec) && !arb_hold;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (w_miss) w_next = FILL;
            FILL:    if (w_done) w_next = IDLE;
            FLUSH:   w_next = IDLE;
            default: w_next = IDLE;
        endcase
        if (flush) w_next = FLUSH;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_idx    <= '0;
            r_tag    <= '0;
            r_k      <= '0;
            r_victim <= '0;
            r_base   <= '0;
        end else if (w_miss) begin
            r_idx    <= w_idx;
            r_tag    <= w_tag;
            r_k      <= '0;
            r_victim <= w_vict;
            r_base   <= imemaddr & ~word_t'(4 * WORDS - 1);
        end else if (w_beat) begin
            r_k <= r_k + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int s = 0; s < SETS; s++) r_ptr[s] <= '0;
        end else if (r_state == FLUSH) begin
            for (int s = 0; s < SETS; s++) r_ptr[s] <= '0;
        end else if (WAYS > 1 && w_done && r_victim == r_ptr[r_idx]) begin
            r_ptr[r_idx] <= r_ptr[r_idx] + 1'b1;
        end
    end

    // The re-hit right after a fill completes the missed request; it is
    // not counted again as a hit.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_refill   <= 1'b0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            r_refill <= w_done;
            if (w_ihit && !r_refill) hit_count <= hit_count + 1'b1;
            if (w_miss) miss_count <= miss_count + 1'b1;
        end
    end

    assign ihit     = w_ihit;
    assign imemload = w_ihit ? w_load : '0;
    assign iREN     = (r_state == FILL);
    assign iaddr    = iREN ? (r_base + word_t'({r_k, 2'b00})) : '0;

endmodule

// File: tb/tb_icache_sa.sv
// Directed bench for icache_sa: scoreboard of expected fetch words and
// fill addresses, checked with immediate assertions.
module tb_icache_sa;

    localparam int WORDS = 2;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        flush;
    logic        arb_hold;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] iaddr;
    logic [31:0] iload;
    logic        iwait;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    int total = 0;
    int bad   = 0;
    int exp_hit  = 0;
    int exp_miss = 0;

    logic [31:0] exp_q [$];
    logic [31:0] ia_q  [$];

    always #5 CLK = ~CLK;

    icache_sa dut (
        .CLK       (CLK),
        .nRST      (nRST),
        .imemREN   (imemREN),
        .imemaddr  (imemaddr),
        .flush     (flush),
        .arb_hold  (arb_hold),
        .ihit      (ihit),
        .imemload  (imemload),
        .iREN      (iREN),
        .iaddr     (iaddr),
        .iload     (iload),
        .iwait     (iwait),
        .hit_count (hit_count),
        .miss_count(miss_count)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, a[17:2]};
    endfunction

    always_comb iload = mem_word(iaddr);

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic fetch(input logic [31:0] a, input bit miss,
                         input int stall);
        int  cyc;
        int  wcnt;
        bit  done;
        logic [31:0] base;
        base = a & ~32'(4 * WORDS - 1);
        exp_q.push_back(mem_word(a & ~32'h3));
        if (miss) begin
            for (int k = 0; k < WORDS; k++) ia_q.push_back(base + 32'(4 * k));
            exp_miss++;
        end else begin
            exp_hit++;
        end
        imemaddr = a;
        imemREN  = 1'b1;
        wcnt = 0;
        cyc  = 0;
        done = 1'b0;
        iwait = (stall > 0);
        while (!done && cyc < 200) begin
            @(negedge CLK);
            if (ihit) begin
                chk("data", imemload, exp_q.pop_front());
                chk("latency", 32'(cyc),
                    miss ? 32'(1 + WORDS * (stall + 1)) : 32'd0);
                chk("beats_left", 32'(ia_q.size()), 32'd0);
                done = 1'b1;
            end else if (iREN) begin
                if (ia_q.size() == 0) begin
                    chk("extra_iREN", {31'd0, iREN}, 32'd0);
                end else begin
                    chk("iaddr", iaddr, ia_q[0]);
                    if (iwait) wcnt++;
                    else begin
                        void'(ia_q.pop_front());
                        wcnt = 0;
                    end
                end
            end
            @(posedge CLK); #1;
            cyc++;
            iwait = (wcnt < stall);
        end
        if (!done) begin
            chk("fetch_timeout", {31'd0, done}, 32'd1);
            exp_q.delete();
            ia_q.delete();
        end
        imemREN = 1'b0;
        iwait   = 1'b0;
        chk("hit_count", hit_count, 32'(exp_hit));
        chk("miss_count", miss_count, 32'(exp_miss));
    endtask

    initial begin
        int n;
        nRST = 1'b0; imemREN = 1'b0; imemaddr = '0;
        flush = 1'b0; arb_hold = 1'b0; iwait = 1'b0;
        #2;
        chk("rst_ihit", {31'd0, ihit}, 32'd0);
        chk("rst_imemload", imemload, 32'd0);
        chk("rst_iREN", {31'd0, iREN}, 32'd0);
        chk("rst_iaddr", iaddr, 32'd0);
        chk("rst_hits", hit_count, 32'd0);
        chk("rst_misses", miss_count, 32'd0);
        @(posedge CLK);
        @(negedge CLK) nRST = 1'b1;
        @(posedge CLK); #1;

        fetch(32'h40, 1'b1, 0);
        fetch(32'h44, 1'b0, 0);

        flush = 1'b1;
        @(posedge CLK); #1;
        flush = 1'b0;
        @(posedge CLK); #1;

        fetch(32'h000, 1'b1, 0);
        fetch(32'h040, 1'b1, 0);
        fetch(32'h080, 1'b1, 0);
        fetch(32'h044, 1'b0, 0);
        fetch(32'h080, 1'b0, 0);
        fetch(32'h000, 1'b1, 0);
        fetch(32'h084, 1'b0, 0);
        fetch(32'h040, 1'b1, 0);

        fetch(32'h120, 1'b1, 3);
        fetch(32'h124, 1'b0, 0);

        imemaddr = 32'h200; imemREN = 1'b1; iwait = 1'b1;
        exp_miss++;
        n = 0;
        @(negedge CLK);
        while (!iREN && n < 20) begin
            @(negedge CLK);
            n++;
        end
        chk("flush_fill_iREN", {31'd0, iREN}, 32'd1);
        chk("flush_fill_iaddr", iaddr, 32'h200);
        flush = 1'b1; imemREN = 1'b0;
        @(posedge CLK); #1;
        flush = 1'b0;
        @(negedge CLK);
        chk("flush_iREN_low", {31'd0, iREN}, 32'd0);
        chk("flush_ihit_low", {31'd0, ihit}, 32'd0);
        @(posedge CLK); #1;
        iwait = 1'b0;
        fetch(32'h200, 1'b1, 0);
        fetch(32'h120, 1'b1, 0);
        fetch(32'h080, 1'b1, 0);

        arb_hold = 1'b1; imemaddr = 32'h2c0; imemREN = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge CLK);
            chk("hold_iREN", {31'd0, iREN}, 32'd0);
            chk("hold_ihit", {31'd0, ihit}, 32'd0);
            @(posedge CLK); #1;
            chk("hold_misses", miss_count, 32'(exp_miss));
        end
        arb_hold = 1'b0;
        fetch(32'h2c0, 1'b1, 0);
        fetch(32'h2c4, 1'b0, 0);

        imemaddr = 32'h300; imemREN = 1'b1;
        @(posedge CLK); #1;
        iwait = 1'b1;
        @(negedge CLK);
        chk("rstfill_iREN", {31'd0, iREN}, 32'd1);
        nRST = 1'b0;
        #1;
        chk("rstfill_iREN_low", {31'd0, iREN}, 32'd0);
        chk("rstfill_misses", miss_count, 32'd0);
        chk("rstfill_hits", hit_count, 32'd0);
        exp_hit = 0; exp_miss = 0;
        imemREN = 1'b0; iwait = 1'b0;
        @(negedge CLK) nRST = 1'b1;
        @(posedge CLK); #1;
        fetch(32'h300, 1'b1, 0);
        fetch(32'h044, 1'b1, 0);
        fetch(32'h304, 1'b0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
